// File: rtl/ahb_lite_master_port.sv
// ahb_lite_master_port: turns a request/acknowledge command stream into pipelined
// AHB-Lite SINGLE transfers with an in-order registered response port.
// Optional build macro AHB_MASTER_ERR_CANCEL_EN: on a slave error the pending
// address phase is flushed and answered with a cancel response.
module ahb_lite_master_port #(
   parameter logic [3:0] HPROT_VALUE      = 4'b0011,
   parameter bit         ADDR_ALIGN_CHECK = 1'b1
) (
   input  logic        CLK,
   input  logic        RES_N,
   input  logic        CMD_REQ,
   output logic        CMD_ACK,
   input  logic        CMD_WRITE,
   input  logic [2:0]  CMD_SIZE,
   input  logic [31:0] CMD_ADDR,
   input  logic [31:0] CMD_WDATA,
   output logic        RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic        RSP_CANCEL,
   output logic [1:0]  M_HTRANS,
   output logic        M_HWRITE,
   output logic [2:0]  M_HSIZE,
   output logic [2:0]  M_HBURST,
   output logic [3:0]  M_HPROT,
   output logic        M_HMASTLOCK,
   output logic [31:0] M_HADDR,
   output logic [31:0] M_HWDATA,
   input  logic        M_HREADY,
   input  logic [31:0] M_HRDATA,
   input  logic        M_HRESP
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // address phase
   logic        aph_valid_q, aph_valid_d;
   logic        aph_bypass_q, aph_bypass_d;
   logic        aph_write_q, aph_write_d;
   logic [2:0]  aph_size_q, aph_size_d;
   logic [31:0] aph_addr_q, aph_addr_d;
   logic [31:0] aph_wdata_q, aph_wdata_d;
   // data phase
   logic        dph_valid_q, dph_valid_d;
   logic        dph_bypass_q, dph_bypass_d;
   logic        dph_write_q, dph_write_d;
   logic [31:0] dph_wdata_q, dph_wdata_d;
   // response
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rsp_cancel_q, rsp_cancel_d;

   logic misalign_s, cmd_ack_s, aph_adv_s, dph_done_s;
   logic flush_s, err_block_s, cancel_fire_s;

   // Size/address combinations a 32-bit AHB-Lite slave cannot take.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lsb);
      case (size)
         3'd0:    is_misaligned = 1'b0;
         3'd1:    is_misaligned = lsb[0];
         3'd2:    is_misaligned = (lsb != 2'b00);
         default: is_misaligned = 1'b1;
      endcase
   endfunction

`ifdef AHB_MASTER_ERR_CANCEL_EN
   logic err_first_s;
   logic err_block_q, err_block_d;
   logic cancel_pend_q, cancel_pend_d;

   // Error-cancel control: first error cycle flushes APH, blocks acks, queues a cancel response.
   always_comb begin
      err_first_s   = dph_valid_q & ~dph_bypass_q & M_HRESP & ~M_HREADY;
      flush_s       = err_first_s & aph_valid_q;
      err_block_s   = err_first_s | err_block_q;
      // the cancel goes out right behind the errored response, when DPH is empty
      cancel_fire_s = cancel_pend_q & rsp_valid_q & ~dph_valid_q;
      err_block_d   = err_first_s;
      if (flush_s) begin
         cancel_pend_d = 1'b1;
      end else if (cancel_fire_s) begin
         cancel_pend_d = 1'b0;
      end else begin
         cancel_pend_d = cancel_pend_q;
      end
   end

   // Error-cancel state registers.
   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         err_block_q   <= 1'b0;
         cancel_pend_q <= 1'b0;
      end else begin
         err_block_q   <= err_block_d;
         cancel_pend_q <= cancel_pend_d;
      end
   end
`else
   // Without the cancel feature a pending command simply proceeds after an error.
   always_comb begin
      flush_s       = 1'b0;
      err_block_s   = 1'b0;
      cancel_fire_s = 1'b0;
   end
`endif

   // Pipeline next-state: command acceptance, APH->DPH advance, DPH completion to response.
   always_comb begin
      misalign_s = ADDR_ALIGN_CHECK & is_misaligned(CMD_SIZE, CMD_ADDR[1:0]);
      cmd_ack_s  = CMD_REQ & (~aph_valid_q | M_HREADY) & ~err_block_s;
      aph_adv_s  = aph_valid_q & M_HREADY;
      dph_done_s = dph_valid_q & M_HREADY;

      aph_valid_d  = aph_valid_q;
      aph_bypass_d = aph_bypass_q;
      aph_write_d  = aph_write_q;
      aph_size_d   = aph_size_q;
      aph_addr_d   = aph_addr_q;
      aph_wdata_d  = aph_wdata_q;
      dph_valid_d  = dph_valid_q;
      dph_bypass_d = dph_bypass_q;
      dph_write_d  = dph_write_q;
      dph_wdata_d  = dph_wdata_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = 32'h0000_0000;
      rsp_err_d    = 1'b0;
      rsp_cancel_d = 1'b0;

      if (cmd_ack_s) begin
         aph_valid_d  = 1'b1;
         aph_bypass_d = misalign_s;
         aph_write_d  = CMD_WRITE;
         aph_size_d   = CMD_SIZE;
         aph_addr_d   = CMD_ADDR;
         aph_wdata_d  = CMD_WDATA;
      end else if (aph_adv_s | flush_s) begin
         aph_valid_d = 1'b0;
      end else begin
         aph_valid_d = aph_valid_q;
      end

      if (aph_adv_s) begin
         dph_valid_d  = 1'b1;
         dph_bypass_d = aph_bypass_q;
         dph_write_d  = aph_write_q;
         dph_wdata_d  = aph_wdata_q;
      end else if (dph_done_s) begin
         dph_valid_d = 1'b0;
      end else begin
         dph_valid_d = dph_valid_q;
      end

      if (dph_done_s) begin
         rsp_valid_d = 1'b1;
         if (~dph_write_q & ~dph_bypass_q) begin
            rsp_rdata_d = M_HRDATA;
         end else begin
            rsp_rdata_d = 32'h0000_0000;
         end
         // a bypassed (misaligned) slot answers with an error, never reaching the bus
         rsp_err_d = M_HRESP | dph_bypass_q;
      end else if (cancel_fire_s) begin
         rsp_valid_d  = 1'b1;
         rsp_err_d    = 1'b1;
         rsp_cancel_d = 1'b1;
      end else begin
         rsp_valid_d = 1'b0;
      end
   end

   // Pipeline and response registers.
   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         aph_valid_q  <= 1'b0;
         aph_bypass_q <= 1'b0;
         aph_write_q  <= 1'b0;
         aph_size_q   <= 3'd0;
         aph_addr_q   <= 32'h0000_0000;
         aph_wdata_q  <= 32'h0000_0000;
         dph_valid_q  <= 1'b0;
         dph_bypass_q <= 1'b0;
         dph_write_q  <= 1'b0;
         dph_wdata_q  <= 32'h0000_0000;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 32'h0000_0000;
         rsp_err_q    <= 1'b0;
         rsp_cancel_q <= 1'b0;
      end else begin
         aph_valid_q  <= aph_valid_d;
         aph_bypass_q <= aph_bypass_d;
         aph_write_q  <= aph_write_d;
         aph_size_q   <= aph_size_d;
         aph_addr_q   <= aph_addr_d;
         aph_wdata_q  <= aph_wdata_d;
         dph_valid_q  <= dph_valid_d;
         dph_bypass_q <= dph_bypass_d;
         dph_write_q  <= dph_write_d;
         dph_wdata_q  <= dph_wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         rsp_cancel_q <= rsp_cancel_d;
      end
   end

   assign CMD_ACK     = cmd_ack_s;
   assign RSP_VALID   = rsp_valid_q;
   assign RSP_RDATA   = rsp_rdata_q;
   assign RSP_ERR     = rsp_err_q;
   assign RSP_CANCEL  = rsp_cancel_q;
   assign M_HTRANS    = (aph_valid_q & ~aph_bypass_q & ~flush_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign M_HWRITE    = aph_write_q;
   assign M_HSIZE     = aph_size_q;
   assign M_HADDR     = aph_addr_q;
   assign M_HWDATA    = dph_valid_q ? dph_wdata_q : 32'h0000_0000;
   assign M_HBURST    = 3'b000;
   assign M_HPROT     = HPROT_VALUE;
   assign M_HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Self-checking bench for ahb_lite_master_port: a memory slave with per-word wait
// states and error injection, plus a command-level reference model.
module tb_ahb_lite_master_port;

   logic        CLK = 1'b0;
   logic        RES_N = 1'b0;
   logic        CMD_REQ = 1'b0;
   logic        CMD_ACK;
   logic        CMD_WRITE = 1'b0;
   logic [2:0]  CMD_SIZE = 3'd0;
   logic [31:0] CMD_ADDR = 32'h0;
   logic [31:0] CMD_WDATA = 32'h0;
   logic        RSP_VALID, RSP_ERR, RSP_CANCEL;
   logic [31:0] RSP_RDATA;
   logic [1:0]  M_HTRANS;
   logic        M_HWRITE, M_HMASTLOCK;
   logic [2:0]  M_HSIZE, M_HBURST;
   logic [3:0]  M_HPROT;
   logic [31:0] M_HADDR, M_HWDATA;
   logic        M_HREADY, M_HRESP;
   logic [31:0] M_HRDATA;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   ahb_lite_master_port dut (
      .CLK(CLK), .RES_N(RES_N), .CMD_REQ(CMD_REQ), .CMD_ACK(CMD_ACK),
      .CMD_WRITE(CMD_WRITE), .CMD_SIZE(CMD_SIZE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_CANCEL(RSP_CANCEL),
      .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST),
      .M_HPROT(M_HPROT), .M_HMASTLOCK(M_HMASTLOCK), .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA),
      .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP)
   );

   always #5 CLK = ~CLK;

   // cycle counter
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
   endfunction

   // ---------------- slave model ----------------
   logic [31:0] mem [0:255];
   int          wait_tab [0:255];
   logic        err_en = 1'b0;
   logic [31:0] err_addr = 32'h0;
   bit          s_init = 1'b0;
   logic        s_act, s_write, s_err, s_eph;
   logic [31:0] s_addr;
   logic [2:0]  s_size;
   int          s_wait;

   // slave response outputs
   always_comb begin
      M_HREADY = !s_act ? 1'b1 : (s_err ? s_eph : (s_wait == 0));
      M_HRESP  = s_act & s_err;
      M_HRDATA = (s_act && !s_write && !s_err && s_wait == 0) ? mem[s_addr[9:2]] : 32'h0;
   end

   // slave data-phase tracking and memory update
   always @(posedge CLK or negedge RES_N) begin
      logic [31:0] word;
      if (!RES_N) begin
         s_act <= 1'b0; s_write <= 1'b0; s_err <= 1'b0; s_eph <= 1'b0;
         s_addr <= 32'h0; s_size <= 3'd0; s_wait <= 0;
         if (!s_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            s_init <= 1'b1;
         end
      end else if (M_HREADY) begin
         if (s_act && s_write && !s_err) begin
            word = mem[s_addr[9:2]];
            for (int b = 0; b < 4; b++)
               if (b >= int'(s_addr[1:0]) && b < int'(s_addr[1:0]) + (1 << s_size))
                  word[8*b +: 8] = M_HWDATA[8*b +: 8];
            mem[s_addr[9:2]] <= word;
         end
         if (M_HTRANS == 2'b10) begin
            s_act <= 1'b1; s_write <= M_HWRITE; s_addr <= M_HADDR; s_size <= M_HSIZE;
            s_eph <= 1'b0; s_err <= (err_en && M_HADDR == err_addr);
            s_wait <= wait_tab[M_HADDR[9:2]];
         end else begin
            s_act <= 1'b0;
         end
      end else begin
         if (s_err) s_eph <= 1'b1;
         else s_wait <= s_wait - 1;
      end
   end

   // ---------------- monitors ----------------
   logic [31:0] iss_addr[$];
   int          iss_cyc[$];
   logic [31:0] rsp_data[$];
   logic        rsp_errl[$];
   logic        rsp_can[$];
   int          rsp_cyc[$];
   int          stab_viol = 0;
   logic        p_hready = 1'b1;
   logic [1:0]  p_htrans = 2'b00;
   logic [31:0] p_haddr = 32'h0, p_hwdata = 32'h0;
   logic        p_hwrite = 1'b0;
   logic [2:0]  p_hsize = 3'd0;

   // record issued transfers, responses, and bus changes during wait states
   always @(negedge CLK) begin
      if (RES_N) begin
         if (M_HTRANS == 2'b10 && M_HREADY) begin
            iss_addr.push_back(M_HADDR); iss_cyc.push_back(cyc);
         end
         if (RSP_VALID) begin
            rsp_data.push_back(RSP_RDATA); rsp_errl.push_back(RSP_ERR);
            rsp_can.push_back(RSP_CANCEL); rsp_cyc.push_back(cyc);
         end
         if (!p_hready && ((p_htrans == 2'b10 && (M_HTRANS !== p_htrans || M_HADDR !== p_haddr ||
             M_HWRITE !== p_hwrite || M_HSIZE !== p_hsize)) || M_HWDATA !== p_hwdata))
            stab_viol <= stab_viol + 1;
         p_hready <= M_HREADY;
      end else begin
         p_hready <= 1'b1;
      end
      p_htrans <= M_HTRANS; p_haddr <= M_HADDR; p_hwdata <= M_HWDATA;
      p_hwrite <= M_HWRITE; p_hsize <= M_HSIZE;
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        cancel;
      logic        chk;
   } exp_t;
   exp_t        exp_q[$];
   logic [31:0] exp_iss[$];
   logic [31:0] ref_mem [0:255];

   // Present one command (call right after a negedge); model its expected outcome at acceptance.
   task automatic send(input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output int ack_c);
      int n;
      logic mis;
      logic [7:0] idx;
      exp_t e;
      n = 0;
      CMD_REQ = 1'b1; CMD_WRITE = w; CMD_SIZE = sz; CMD_ADDR = a; CMD_WDATA = d;
      #1;
      while (CMD_ACK !== 1'b1 && n < 100) begin
         @(negedge CLK); #1; n++;
      end
      ack_c = cyc;
      checks++;
      if (CMD_ACK !== 1'b1) begin
         failures++;
         $display("FAIL cmd_ack_timeout addr=%h ack=%b required=1", a, CMD_ACK);
      end
      mis = (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) || (sz > 3'd2);
      idx = a[9:2];
      e.data = 32'h0; e.err = 1'b0; e.cancel = 1'b0; e.chk = 1'b1;
      if (mis) begin
         e.err = 1'b1;
      end else begin
         exp_iss.push_back(a);
         if (err_en && a == err_addr) begin
            e.err = 1'b1; e.chk = 1'b0;
         end else if (w) begin
            for (int b = 0; b < 4; b++)
               if (b >= int'(a[1:0]) && b < int'(a[1:0]) + (1 << sz))
                  ref_mem[idx][8*b +: 8] = d[8*b +: 8];
         end else begin
            e.data = ref_mem[idx];
         end
      end
      exp_q.push_back(e);
      @(negedge CLK);
      CMD_REQ = 1'b0;
   endtask

   // Wait (bounded) until target responses have been seen, then settle two cycles.
   task automatic drain(input int target);
      int n;
      n = 0;
      while (rsp_data.size() < target && n < 300) begin
         @(negedge CLK); n++;
      end
      repeat (2) @(negedge CLK);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge CLK);
      #1;
      checks++;
      if ({RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA, M_HTRANS, M_HWRITE, M_HSIZE, M_HADDR, M_HWDATA} !== 105'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0", {RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA,
                  M_HTRANS, M_HWRITE, M_HSIZE, M_HADDR, M_HWDATA});
      end
      checks++;
      if ({M_HBURST, M_HPROT, M_HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
         failures++;
         $display("FAIL const_outputs got=%b required=%b", {M_HBURST, M_HPROT, M_HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
      end
      @(negedge CLK);
      RES_N = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_write_read();
      int eb, rb, ib, a0, a1;
      eb = exp_q.size(); rb = rsp_data.size(); ib = iss_addr.size();
      send(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, a0);
      send(1'b0, 3'd2, 32'h100, 32'h0, a1);
      drain(rb + 2);
      checks++;
      if (a1 !== a0 + 1) begin failures++; $display("FAIL wr_b2b_ack got=%0d required=%0d", a1, a0 + 1); end
      checks++;
      if (iss_cyc[ib] !== a0 + 1 || iss_cyc[ib + 1] !== a1 + 1) begin
         failures++; $display("FAIL wr_nonseq_latency got=%0d,%0d required=%0d,%0d", iss_cyc[ib], iss_cyc[ib + 1], a0 + 1, a1 + 1);
      end
      checks++;
      if (rsp_data.size() - rb !== 2) begin failures++; $display("FAIL wr_rsp_count got=%0d required=2", rsp_data.size() - rb); end
      checks++;
      if (rsp_cyc[rb] !== a0 + 3 || rsp_cyc[rb + 1] !== a1 + 3) begin
         failures++; $display("FAIL wr_rsp_latency got=%0d,%0d required=%0d,%0d", rsp_cyc[rb], rsp_cyc[rb + 1], a0 + 3, a1 + 3);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rsp_data[rb + i] !== exp_q[eb + i].data || rsp_errl[rb + i] !== 1'b0) begin
            failures++; $display("FAIL wr_rsp%0d data=%h err=%b required data=%h err=0", i, rsp_data[rb + i], rsp_errl[rb + i], exp_q[eb + i].data);
         end
      end
      checks++;
      if (rsp_data[rb + 1] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_readback got=%h required=deadbeef", rsp_data[rb + 1]); end
   endtask

   task automatic test_back_to_back();
      int eb, rb, ib, sv, ack;
      eb = exp_q.size(); rb = rsp_data.size(); ib = iss_addr.size(); sv = stab_viol;
      for (int i = 0; i < 4; i++) wait_tab[i] = i;
      for (int i = 0; i < 4; i++) send(1'b0, 3'd2, 32'(4 * i), 32'h0, ack);
      drain(rb + 4);
      checks++;
      if (rsp_data.size() - rb !== 4) begin failures++; $display("FAIL b2b_rsp_count got=%0d required=4", rsp_data.size() - rb); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rsp_data[rb + i] !== exp_q[eb + i].data || rsp_errl[rb + i] !== 1'b0 || iss_addr[ib + i] !== 32'(4 * i)) begin
            failures++; $display("FAIL b2b_%0d data=%h err=%b addr=%h required data=%h err=0 addr=%h", i, rsp_data[rb + i],
                                 rsp_errl[rb + i], iss_addr[ib + i], exp_q[eb + i].data, 32'(4 * i));
         end
      end
      checks++;
      if (stab_viol !== sv) begin failures++; $display("FAIL b2b_wait_stability got=%0d changes required=0", stab_viol - sv); end
      for (int i = 0; i < 4; i++) wait_tab[i] = 0;
   endtask

   task automatic test_byte_lane();
      int rb, ack;
      rb = rsp_data.size();
      send(1'b1, 3'd0, 32'h103, 32'hAB00_0000, ack);
      send(1'b0, 3'd2, 32'h100, 32'h0, ack);
      drain(rb + 2);
      checks++;
      if (rsp_data[rb + 1] !== 32'hABAD_BEEF || rsp_errl[rb + 1] !== 1'b0) begin
         failures++; $display("FAIL byte_lane data=%h err=%b required data=abadbeef err=0", rsp_data[rb + 1], rsp_errl[rb + 1]);
      end
   endtask

   task automatic test_misaligned();
      int rb, ib, ack;
      rb = rsp_data.size(); ib = iss_addr.size();
      send(1'b0, 3'd2, 32'h102, 32'h0, ack);
      send(1'b1, 3'd1, 32'h101, 32'h1234_5678, ack);
      send(1'b0, 3'd3, 32'h100, 32'h0, ack);
      drain(rb + 3);
      checks++;
      if (iss_addr.size() !== ib) begin failures++; $display("FAIL misalign_no_bus got=%0d transfers required=0", iss_addr.size() - ib); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rsp_data[rb + i] !== 32'h0 || rsp_errl[rb + i] !== 1'b1 || rsp_can[rb + i] !== 1'b0) begin
            failures++; $display("FAIL misalign_rsp%0d data=%h err=%b cancel=%b required data=0 err=1 cancel=0", i,
                                 rsp_data[rb + i], rsp_errl[rb + i], rsp_can[rb + i]);
         end
      end
   endtask

   task automatic test_error();
      int eb, rb, ib, a0, ack;
      exp_t e;
      eb = exp_q.size(); rb = rsp_data.size(); ib = iss_addr.size();
      err_en = 1'b1; err_addr = 32'h200;
      send(1'b0, 3'd2, 32'h200, 32'h0, a0);
      send(1'b0, 3'd2, 32'h204, 32'h0, ack);
`ifdef AHB_MASTER_ERR_CANCEL_EN
      // the command sitting in the address phase at the first error cycle is cancelled
      e = exp_q.pop_back();
      e.data = 32'h0; e.err = 1'b1; e.cancel = 1'b1; e.chk = 1'b1;
      exp_q.push_back(e);
      void'(exp_iss.pop_back());
`endif
      drain(rb + 2);
      err_en = 1'b0;
      checks++;
      if (rsp_data.size() - rb !== 2) begin failures++; $display("FAIL err_rsp_count got=%0d required=2", rsp_data.size() - rb); end
      for (int i = 0; i < 2; i++) begin
         e = exp_q[eb + i];
         checks++;
         if (rsp_errl[rb + i] !== e.err || rsp_can[rb + i] !== e.cancel || (e.chk && rsp_data[rb + i] !== e.data)) begin
            failures++; $display("FAIL err_rsp%0d data=%h err=%b cancel=%b required data=%h err=%b cancel=%b", i,
                                 rsp_data[rb + i], rsp_errl[rb + i], rsp_can[rb + i], e.data, e.err, e.cancel);
         end
      end
      checks++;
      if (rsp_cyc[rb] !== a0 + 4 || rsp_cyc[rb + 1] !== a0 + 5) begin
         failures++; $display("FAIL err_rsp_timing got=%0d,%0d required=%0d,%0d", rsp_cyc[rb], rsp_cyc[rb + 1], a0 + 4, a0 + 5);
      end
      checks++;
      if (iss_addr.size() - ib !== exp_iss.size() - ib) begin
         failures++; $display("FAIL err_issue_count got=%0d required=%0d", iss_addr.size() - ib, exp_iss.size() - ib);
      end
      for (int i = ib; i < exp_iss.size(); i++) begin
         checks++;
         if (iss_addr[i] !== exp_iss[i]) begin failures++; $display("FAIL err_issue_addr got=%h required=%h", iss_addr[i], exp_iss[i]); end
      end
   endtask

   task automatic test_random();
      int eb, rb, ib, sv, ack, n, bad;
      logic w;
      logic [2:0] sz;
      logic [31:0] a;
      exp_t e;
      eb = exp_q.size(); rb = rsp_data.size(); ib = iss_addr.size(); sv = stab_viol;
      n = 40; bad = 0;
      for (int i = 8'hC0; i <= 8'hCF; i++) wait_tab[i] = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         w  = 1'($urandom_range(0, 1));
         sz = 3'($urandom_range(0, 3));
         a  = 32'h300 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 5) != 0 && sz <= 3'd2) a = a & ~(32'(1 << sz) - 32'd1);
         send(w, sz, a, $urandom(), ack);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
      drain(rb + n);
      checks++;
      if (rsp_data.size() - rb !== n) begin failures++; $display("FAIL rand_rsp_count got=%0d required=%0d", rsp_data.size() - rb, n); end
      for (int i = 0; i < n; i++) begin
         e = exp_q[eb + i];
         checks++;
         if (rsp_errl[rb + i] !== e.err || rsp_can[rb + i] !== 1'b0 || rsp_data[rb + i] !== e.data) begin
            failures++; $display("FAIL rand_rsp%0d data=%h err=%b cancel=%b required data=%h err=%b cancel=0", i,
                                 rsp_data[rb + i], rsp_errl[rb + i], rsp_can[rb + i], e.data, e.err);
         end
      end
      for (int i = ib; i < exp_iss.size(); i++) if (iss_addr[i] !== exp_iss[i]) bad++;
      checks++;
      if (bad != 0 || iss_addr.size() !== exp_iss.size()) begin
         failures++; $display("FAIL rand_issue_order wrong=%0d count=%0d required wrong=0 count=%0d", bad, iss_addr.size(), exp_iss.size());
      end
      checks++;
      if (stab_viol !== sv) begin failures++; $display("FAIL rand_wait_stability got=%0d changes required=0", stab_viol - sv); end
   endtask

   task automatic test_reset_mid();
      int rb, ack;
      wait_tab[8'h3C] = 3;
      rb = rsp_data.size();
      send(1'b0, 3'd2, 32'h0F0, 32'h0, ack);
      @(negedge CLK);
      #2;
      RES_N = 1'b0;
      #1;
      checks++;
      if ({RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA, M_HTRANS, M_HWRITE, M_HSIZE, M_HADDR, M_HWDATA} !== 105'h0) begin
         failures++;
         $display("FAIL midreset_outputs got=%h required=0", {RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA,
                  M_HTRANS, M_HWRITE, M_HSIZE, M_HADDR, M_HWDATA});
      end
      repeat (2) @(negedge CLK);
      RES_N = 1'b1;
      repeat (10) @(negedge CLK);
      checks++;
      if (rsp_data.size() !== rb) begin failures++; $display("FAIL midreset_no_rsp got=%0d responses required=0", rsp_data.size() - rb); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      test_reset();
      test_write_read();
      test_back_to_back();
      test_byte_lane();
      test_misaligned();
      test_error();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
